// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Central pipeline controller for the 5-stage core. Produces the stall and
//   flush enables for the pipeline registers and the EX-stage forwarding
//   selects. It also runs a data-memory wait FSM with a timeout watchdog and
//   keeps a saturating count of stalled cycles.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-low reset
//   Rs1D, Rs2D          source registers of the ID instruction
//   Rs1E, Rs2E, RdE     source and destination registers of the EX instruction
//   MemToRegE           EX instruction is a load
//   PCSrcE              branch/jump taken, resolved in EX
//   RdM, RegWriteM      MEM destination register and its write enable
//   MemReqM, MemReadyM  MEM data-memory request and completion
//   RdW, RegWriteW      WB destination register and its write enable
//   StallF..StallM      hold enables for PC, IF/ID, ID/EX, EX/MEM
//   FlushD, FlushE      clear IF/ID, ID/EX to a bubble
//   FlushW              load a bubble into MEM/WB
//   ForwardAE/BE        00 = register file, 01 = WB result, 10 = MEM ALU result
//   MemErr              sticky memory-timeout flag
//   StallCount          saturating count of cycles with any stall asserted
//   dbg_state_o         current wait-FSM state (00 RUN, 01 MEM_WAIT, 10 ERROR)
//
// Handshake: the memory access in MEM is a valid/ready pair. MemReqM is the
// valid, MemReadyM the ready; the access completes in the cycle both are high
// (in RUN) or in the cycle MemReadyM is high (in MEM_WAIT). Every cycle
// without completion freezes the pipeline.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             MemToRegE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [1:0]       dbg_state_o
);

  // Counter holds 0..TIMEOUT-1.
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               ms;
  logic               lu;
  logic               any_stall;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic (also steers the wait counter)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (MemReadyM) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WCNT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_ERROR: begin
        // Only reset leaves ERROR; MemReadyM is deliberately ignored.
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  assign any_stall = StallF | StallD | StallE | StallM;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (any_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // Memory stall depends on the FSM state: a fresh request stalls only if it
  // is not ready in its first cycle, so a single-cycle access costs nothing.
  always_comb begin
    ms = 1'b0;
    case (state_q)
      ST_RUN:      ms = MemReqM && !MemReadyM;
      ST_MEM_WAIT: ms = !MemReadyM;
      ST_ERROR:    ms = 1'b1;
      default:     ms = 1'b0;
    endcase
  end

  assign lu = MemToRegE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // While memory stalls, EX and ID are frozen, so a pending branch or
  // load-use is simply seen again once the stall drops.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (ms) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Forwarding: MEM result is younger than WB result, so it wins.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reset) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
        ForwardAE = 2'b10;
      end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
        ForwardAE = 2'b01;
      end
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
        ForwardBE = 2'b10;
      end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
        ForwardBE = 2'b01;
      end
    end
  end

  assign MemErr      = (state_q == ST_ERROR);
  assign StallCount  = stall_cnt_q;
  assign dbg_state_o = state_q;

endmodule
